// File: rtl/msg_frame_serializer.sv
// msg_frame_serializer
//
// Turns each message from the upstream generator into one 8-bit asynchronous serial frame:
// a start bit (0), five payload bits {msg_type, num} sent LSB first, an even-parity bit and
// a stop bit (1). Every bit lasts CLKS_PER_BIT clock cycles.
//
// A new frame is requested on the 0->1 transition of msg_enable. One request that arrives
// while a frame is in flight is held in a single pending slot, and it goes out back-to-back
// after the current frame. Any further request is dropped, and overrun pulses for it.
//
// Ports:
//   clk         system clock; all logic is on the rising edge
//   rst_neg     asynchronous active-low reset
//   msg_enable  request strobe/level; a frame is requested on its rising transition
//   msg_type    payload bit 4, sampled with the request
//   num         payload bits 3:0, sampled with the request
//   tx          registered serial line, idles high
//   busy        a frame is on the line or pending
//   frame_done  one-cycle pulse in the last cycle of each stop bit
//   overrun     one-cycle pulse (registered) after a request is dropped

module msg_frame_serializer #(
  parameter int unsigned CLKS_PER_BIT = 50,
  parameter int unsigned DATA_W       = 5
) (
  input  logic       clk,
  input  logic       rst_neg,
  input  logic       msg_enable,
  input  logic       msg_type,
  input  logic [3:0] num,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LastBit = 3'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [DATA_W-1:0]   act_q, act_d;
  logic [DATA_W-1:0]   pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic                msg_en_q;
  logic                tx_q, tx_d;
  logic                overrun_q, overrun_d;

  logic                req;
  logic [DATA_W-1:0]   req_data;
  logic                last;
  logic                stop_last;

  assign req       = msg_enable & ~msg_en_q;
  assign req_data  = {msg_type, num};
  assign last      = (cnt_q == CntMax);
  assign stop_last = (state_q == StStop) && last;

  // State register. msg_en_q resets high so that a level held through reset is not
  // mistaken for a request.
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      msg_en_q   <= 1'b1;
      tx_q       <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      msg_en_q   <= msg_enable;
      tx_q       <= tx_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overrun_d  = 1'b0;

    // The cycle counter runs in every bit state and clears only at the end of a bit.
    if (state_q == StIdle || last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StStart;
          act_d   = req_data;
        end
      end
      StStart: begin
        if (last) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (last) begin
          if (bit_q == LastBit) begin
            state_d = StParity;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (last) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (last) begin
          if (pend_vld_q) begin
            // Pending goes on the line next. A request in this same cycle refills the
            // slot instead of being dropped.
            state_d = StStart;
            act_d   = pend_q;
            if (req) begin
              pend_d = req_data;
            end else begin
              pend_vld_d = 1'b0;
            end
          end else if (req) begin
            state_d = StStart;
            act_d   = req_data;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A request mid-frame goes to the pending slot if it is free, and is dropped otherwise.
    if (req && (state_q != StIdle) && !stop_last) begin
      if (!pend_vld_q) begin
        pend_d     = req_data;
        pend_vld_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Outputs. tx is computed from the next state and registered, so the line never glitches.
  always_comb begin
    busy       = (state_q != StIdle) || pend_vld_q;
    frame_done = stop_last;
    tx_d       = 1'b1;
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = act_d[bit_d];
      StParity: tx_d = ^act_d;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_msg_frame_serializer.sv
// Scoreboard bench for msg_frame_serializer with CLKS_PER_BIT = 4.
// Stimulus pushes the expected frame bits; a negedge monitor recovers each 32-cycle frame
// from tx and compares it, together with frame_done and busy, against the queue head.

module tb_msg_frame_serializer;

  localparam int unsigned Cpb      = 4;
  localparam int          FrameCyc = 8 * Cpb;

  logic       clk        = 1'b0;
  logic       rst_neg    = 1'b0;
  logic       msg_enable = 1'b1;
  logic       msg_type   = 1'b0;
  logic [3:0] num        = 4'd0;
  logic       tx, busy, frame_done, overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sb[$];
  logic [7:0]  exp_bits;
  logic [31:0] tx_w, fd_w, busy_w;
  int pos       = -1;
  int cyc       = 0;
  int last_end  = -100;
  int last_gap  = 0;
  int frames    = 0;
  int fd_count  = 0;
  int ovr_count = 0;

  msg_frame_serializer #(
    .CLKS_PER_BIT(Cpb),
    .DATA_W      (5)
  ) dut (
    .clk       (clk),
    .rst_neg   (rst_neg),
    .msg_enable(msg_enable),
    .msg_type  (msg_type),
    .num       (num),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  initial forever #5 clk = ~clk;

  // Bit 0 is the start bit, bit 7 the stop bit.
  function automatic logic [7:0] frame_bits(input logic t, input logic [3:0] n);
    logic [4:0] d;
    d = {t, n};
    return {1'b1, ^d, d, 1'b0};
  endfunction

  function automatic logic [31:0] wave(input logic [7:0] b);
    logic [31:0] w;
    for (int i = 0; i < FrameCyc; i++) w[i] = b[i / Cpb];
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request; the payload is scrambled afterwards to confirm it was captured.
  task automatic request(input logic t, input logic [3:0] n);
    msg_type   = t;
    num        = n;
    msg_enable = 1'b1;
    sb.push_back(frame_bits(t, n));
    tick();
    msg_enable = 1'b0;
    msg_type   = ~t;
    num        = ~n;
    tick();
  endtask

  // Issue a request that must be dropped and flagged.
  task automatic request_drop(input logic t, input logic [3:0] n);
    msg_type   = t;
    num        = n;
    msg_enable = 1'b1;
    tick();
    check("overrun_pulse", overrun, 1'b1);
    msg_enable = 1'b0;
    tick();
    check("overrun_single", overrun, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || pos >= 0 || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle: timeout after %0d cycles, %0d frames outstanding", n, sb.size());
    end
  endtask

  // Monitor: recover frames from tx and compare against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (frame_done) fd_count++;
    if (overrun) ovr_count++;
    if (!rst_neg) begin
      pos = -1;
    end else begin
      if (pos < 0 && tx == 1'b0) begin
        pos      = 0;
        last_gap = cyc - last_end;
      end
      if (pos >= 0) begin
        tx_w[pos]   = tx;
        fd_w[pos]   = frame_done;
        busy_w[pos] = busy;
        if (pos == FrameCyc - 1) begin
          frames++;
          last_end = cyc;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got tx %h expected no frame", tx_w);
          end else begin
            exp_bits = sb.pop_front();
            check("frame_tx", tx_w, wave(exp_bits));
            check("frame_done_pos", fd_w, 32'h8000_0000);
            check("busy_in_frame", busy_w, 32'hffff_ffff);
          end
          pos = -1;
        end else begin
          pos++;
        end
      end
    end
  end

  initial begin
    int f0, d0, o0;

    // 1: reset with msg_enable held high; no frame may launch.
    rst_neg    = 1'b0;
    msg_enable = 1'b1;
    repeat (3) tick();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst_neg = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("held_enable_idle", {tx, busy}, 2'b10);
    end
    check("held_enable_frames", frames, 0);
    msg_enable = 1'b0;
    tick();

    // 2: single frame, exact frame_done and busy drop timing.
    f0 = frames;
    d0 = fd_count;
    request(1'b1, 4'b0101);
    repeat (30) tick();
    check("stop_last_done", frame_done, 1'b1);
    check("stop_last_busy", busy, 1'b1);
    tick();
    check("after_frame_done", frame_done, 1'b0);
    check("after_frame_busy", busy, 1'b0);
    wait_idle(100);
    check("t2_frames", frames - f0, 1);
    check("t2_done_count", fd_count - d0, 1);

    // 3: second request 10 cycles in goes out back-to-back.
    f0 = frames;
    o0 = ovr_count;
    request(1'b1, 4'b0101);
    repeat (8) tick();
    request(1'b0, 4'b0011);
    wait_idle(200);
    check("t3_frames", frames - f0, 2);
    check("t3_gap", last_gap, 1);
    check("t3_overrun", ovr_count - o0, 0);

    // 4: three requests in one frame; the third is dropped.
    f0 = frames;
    d0 = fd_count;
    o0 = ovr_count;
    request(1'b0, 4'b1010);
    repeat (4) tick();
    request(1'b1, 4'b1100);
    repeat (4) tick();
    request_drop(1'b0, 4'b0001);
    wait_idle(200);
    check("t4_frames", frames - f0, 2);
    check("t4_done_count", fd_count - d0, 2);
    check("t4_overrun_count", ovr_count - o0, 1);

    // 5: request on the stop bit's last cycle with pending empty.
    f0 = frames;
    o0 = ovr_count;
    request(1'b0, 4'b0110);
    repeat (30) tick();
    request(1'b1, 4'b1001);
    wait_idle(200);
    check("t5_frames", frames - f0, 2);
    check("t5_gap", last_gap, 1);
    check("t5_overrun", ovr_count - o0, 0);

    // 6: reset in the DATA state abandons the frame immediately.
    request(1'b1, 4'b0111);
    repeat (10) tick();
    rst_neg = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    sb.delete();
    d0 = fd_count;
    repeat (2) tick();
    check("midrst_done", frame_done, 1'b0);
    rst_neg = 1'b1;
    tick();
    f0 = frames;
    request(1'b0, 4'b1110);
    wait_idle(100);
    check("t6_frames", frames - f0, 1);
    check("t6_done_count", fd_count - d0, 1);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
